// File: rtl/ao_pipe_pkg.sv
// ao_pipe_pkg: shared defaults, stage state type and the AND-OR reduction used by ao_pipe.
// Contents:
//   AO_WIDTH / AO_TERMS   default operand width and term count
//   AO_MAX_W / AO_MAX_T   largest width / term count ao_reduce can handle
//   stage_e               main output register state (EMPTY, FULL)
//   ao_reduce(a, b, inv)  per-bit OR of the term-wise ANDs, optionally inverted
package ao_pipe_pkg;
  localparam int AO_WIDTH = 8;
  localparam int AO_TERMS = 2;
  localparam int AO_MAX_W = 64;
  localparam int AO_MAX_T = 16;
  localparam int AO_MAX_BITS = AO_MAX_W * AO_MAX_T;
  typedef enum logic {EMPTY, FULL} stage_e;
  // Operands use a fixed AO_MAX_W stride per term; unused terms/bits are zero, so they
  // add nothing to the OR. Callers truncate the result to their own width.
  function automatic logic [AO_MAX_W-1:0] ao_reduce(input logic [AO_MAX_BITS-1:0] a,
                                                    input logic [AO_MAX_BITS-1:0] b,
                                                    input logic invert);
    logic [AO_MAX_W-1:0] r;
    r = '0;
    for (int t = 0; t < AO_MAX_T; t++) r |= a[t*AO_MAX_W +: AO_MAX_W] & b[t*AO_MAX_W +: AO_MAX_W];
    return invert ? ~r : r;
  endfunction
endpackage

// File: rtl/ao_pipe_skid.sv
// ao_pipe_skid: one-entry skid register with valid/ready on both sides and a registered ready.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_valid_i/s_ready_o   upstream handshake (s_ready_o is a flop output)
//   s_data_i              upstream data
//   m_valid_o/m_ready_i   downstream handshake
//   m_data_o              downstream data (held entry when full, else pass-through)
module ao_pipe_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);
  logic             full_q, full_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             capture;
  always_comb begin
    capture = ~full_q & s_valid_i & rdy_q & ~m_ready_i;
    full_d  = full_q ? ~m_ready_i : capture;
    data_d  = capture ? s_data_i : data_q;
    rdy_d   = ~full_d;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b1;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= rdy_d;
      data_q <= data_d;
    end
  end
  assign s_ready_o = rdy_q;
  assign m_valid_o = full_q | s_valid_i;
  assign m_data_o  = full_q ? data_q : s_data_i;
endmodule

// File: rtl/ao_pipe.sv
// ao_pipe: pipelined AND-OR(-invert) merge stage with valid/ready output register.
// Build option: define AO_PIPE_SKID_BUF_EN to add a one-entry skid buffer and register ready_o.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   a_i, b_i            TERMS operands of WIDTH bits, term t at [t*WIDTH +: WIDTH]
//   valid_i, ready_o    input handshake
//   y_o, valid_o        registered result and its valid
//   ready_i             downstream ready
module ao_pipe
  import ao_pipe_pkg::*;
#(
  parameter int WIDTH  = AO_WIDTH,
  parameter int TERMS  = AO_TERMS,
  parameter int INVERT = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [TERMS*WIDTH-1:0] a_i,
  input  logic [TERMS*WIDTH-1:0] b_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [WIDTH-1:0]       y_o,
  output logic                   valid_o,
  input  logic                   ready_i
);
  logic [AO_MAX_BITS-1:0] a_ext, b_ext;
  logic [WIDTH-1:0]       f;
  logic                   up_valid, up_ready;
  logic [WIDTH-1:0]       up_data;
  stage_e                 state_q, state_d;
  logic [WIDTH-1:0]       y_q, y_d;
  // Repack into the fixed-stride layout ao_reduce expects.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    for (int t = 0; t < TERMS; t++) begin
      a_ext[t*AO_MAX_W +: WIDTH] = a_i[t*WIDTH +: WIDTH];
      b_ext[t*AO_MAX_W +: WIDTH] = b_i[t*WIDTH +: WIDTH];
    end
    f = WIDTH'(ao_reduce(a_ext, b_ext, INVERT != 0));
  end
`ifdef AO_PIPE_SKID_BUF_EN
  ao_pipe_skid #(.WIDTH(WIDTH)) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (valid_i),
    .s_ready_o (ready_o),
    .s_data_i  (f),
    .m_valid_o (up_valid),
    .m_ready_i (up_ready),
    .m_data_o  (up_data)
  );
`else
  assign up_valid = valid_i;
  assign up_data  = f;
  assign ready_o  = up_ready;
`endif
  // The main register can take a beat when empty or when its current beat leaves this cycle.
  assign up_ready = ready_i | (state_q == EMPTY);
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    if (up_valid & up_ready) begin
      state_d = FULL;
      y_d     = up_data;
    end else if (ready_i) begin
      state_d = EMPTY;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end
  assign valid_o = (state_q == FULL);
  assign y_o     = y_q;
endmodule
